// File: rtl/mixer_pkg.sv
// Shared types and constants for the voice mixer.
package mixer_pkg;
  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT,
    SUM,
    DONE
  } state_t;

  localparam int SAMPLE_W   = 16;
  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  function automatic int acc_w(input int voices);
    return SAMPLE_W + $clog2(voices);
  endfunction
endpackage

// File: rtl/mix_clamp.sv
// Saturates a signed accumulator of width W to a 16-bit sample.
module mix_clamp
  import mixer_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0]        acc,
  output logic signed [SAMPLE_W-1:0] y
);
  localparam logic signed [W-1:0] HI = W'(SAMPLE_MAX);
  localparam logic signed [W-1:0] LO = W'(SAMPLE_MIN);

  always_comb begin
    y = acc[SAMPLE_W-1:0];
    if (acc > HI)
      y = SAMPLE_W'(SAMPLE_MAX);
    else if (acc < LO)
      y = SAMPLE_W'(SAMPLE_MIN);
  end
endmodule

// File: rtl/voice_mixer.sv
// Requests, collects and sums one sample per enabled voice per frame.
// VOICE_MIXER_SATURATE_EN selects clamping instead of shift scaling.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int VOICES  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_frame,
  input  logic [VOICES-1:0]          voice_enable,
  input  logic [VOICES-1:0]          sample_ready,
  input  logic [VOICES*SAMPLE_W-1:0] samples,
  output logic [VOICES-1:0]          generate_next,
  output logic [SAMPLE_W-1:0]        mixed_sample,
  output logic                       mixed_valid,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       overrun_err
);
  localparam int ACC_W = acc_w(VOICES);
  localparam int LOG_V = $clog2(VOICES);
  localparam int KW    = (LOG_V > 0) ? LOG_V : 1;

  state_t state, state_nx;

  logic [VOICES-1:0] en_q;
  logic [VOICES-1:0] mask;
  logic [VOICES-1:0] cap;
  logic [7:0]        cnt;
  logic [KW-1:0]     k;
  logic              done_wait;
  logic              time_up;
  logic              last_k;

  logic signed [SAMPLE_W-1:0] slot [VOICES];
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_nx;
  logic signed [SAMPLE_W-1:0] result;

  assign cap       = sample_ready & en_q & ~mask;
  assign done_wait = ((mask | cap) == en_q);
  assign time_up   = (cnt == 8'd1);
  assign last_k    = (k == KW'(VOICES - 1));
  assign acc_nx    = acc + ACC_W'(slot[k]);
  assign busy      = (state != IDLE);

`ifdef VOICE_MIXER_SATURATE_EN
  mix_clamp #(
    .W(ACC_W)
  ) u_clamp (
    .acc(acc_nx),
    .y  (result)
  );
`else
  assign result = SAMPLE_W'(acc_nx >>> LOG_V);
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (new_frame) state_nx = REQUEST;
      REQUEST: state_nx = WAIT;
      WAIT:    if (done_wait || time_up) state_nx = SUM;
      SUM:     if (last_k) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q          <= '0;
      mask          <= '0;
      cnt           <= '0;
      k             <= '0;
      acc           <= '0;
      generate_next <= '0;
      mixed_sample  <= '0;
      mixed_valid   <= 1'b0;
      timeout_err   <= 1'b0;
      overrun_err   <= 1'b0;
      for (int i = 0; i < VOICES; i++)
        slot[i] <= '0;
    end else begin
      generate_next <= '0;
      mixed_valid   <= 1'b0;
      if (new_frame && state != IDLE)
        overrun_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (new_frame) begin
            en_q          <= voice_enable;
            mask          <= '0;
            generate_next <= voice_enable;
            for (int i = 0; i < VOICES; i++)
              slot[i] <= '0;
          end
        end
        REQUEST: cnt <= 8'(TIMEOUT);
        WAIT: begin
          mask <= mask | cap;
          cnt  <= cnt - 8'd1;
          acc  <= '0;
          k    <= '0;
          for (int i = 0; i < VOICES; i++)
            if (cap[i])
              slot[i] <= samples[i*SAMPLE_W +: SAMPLE_W];
          // completion in the final cycle beats the timeout
          if (!done_wait && time_up)
            timeout_err <= 1'b1;
        end
        SUM: begin
          acc <= acc_nx;
          k   <= k + KW'(1);
          if (last_k) begin
            mixed_sample <= result;
            mixed_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
